hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core. Drives enable/flush for PC, IF/ID, ID/EX, EX/MEM buffers.
//  Resolves load-use hazards (1-cycle stall + bubble), taken branches resolved in MEM (3-stage flush).
//  Freezes the whole pipeline while data memory is busy (req/ack handshake). Keeps a saturating stall counter.
// PARAMETERS
//  CNT_W        16   width of stall_cnt
//  WAIT_W       8    width of internal memory-wait counter
//  TIMEOUT_CYC  200  MEM_WAIT cycles before timeout; used only with MEM_TIMEOUT_EN; must be < 2**WAIT_W
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      reset, asynchronous, active-low
//  id_rs       in   5      rs field of instruction in IF/ID
//  id_rt       in   5      rt field of instruction in IF/ID
//  ex_memread  in   1      MemRead bit of ID/EX control
//  ex_rt       in   5      destination rt held in ID/EX
//  mem_branch  in   1      Branch bit of EX/MEM control
//  mem_zero    in   1      ALU zero flag held in EX/MEM
//  mem_access  in   1      EX/MEM instr is lw/sw (MemRead|MemWrite)
//  dmem_ack    in   1      data memory done this cycle
//  pc_en, ifid_en, idex_en, exmem_en  out 1 each  load enable of PC / buffer
//  ifid_flush, idex_flush, exmem_flush out 1 each  load bubble (all-zero control) at next edge
//  pc_src      out  1      1 = select branch target (EX/MEM add) for PC
//  dmem_req    out  1      data memory request
//  stall_cnt   out  CNT_W  registered count of stall/freeze cycles, saturating
//  err         out  1      registered, sticky memory-timeout flag (always 0 without macro)
// BEHAVIOUR
//  - States: RUN, MEM_WAIT, ERR (ERR reachable only with macro). Reset -> RUN.
//  - rst_n low (async): state RUN, wait cnt 0, stall_cnt 0, err 0.
//    Comb outputs forced: all *_en 0, all *_flush 1, pc_src 0, dmem_req 0.
//  - Outputs comb from state + inputs; decode per cycle, first match wins:
//   1 FREEZE: mem_access & !dmem_ack (RUN or MEM_WAIT).
//     All *_en 0, flushes 0, pc_src 0, dmem_req 1.
//   2 BRANCH: mem_branch & mem_zero. All *_en 1, ifid/idex/exmem_flush 1, pc_src 1.
//   3 LOADUSE: ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
//     pc_en 0, ifid_en 0, idex_flush 1, idex_en 1, exmem_en 1.
//   4 NORMAL: all *_en 1, flushes 0, pc_src 0.
//  - dmem_req = mem_access in RUN/MEM_WAIT; 0 in ERR. Zero-wait access (ack same cycle) -> no freeze.
//  - Transitions: RUN->MEM_WAIT on FREEZE; MEM_WAIT->RUN on dmem_ack (that cycle decodes rules 2-4).
//  - Wait counter: cleared on entry to MEM_WAIT; +1 per MEM_WAIT cycle; saturates at all-ones.
//  - stall_cnt +1 each cycle rule 1 or 3 applies; holds at 2**CNT_W-1; no wrap.
//  - Branch flush is one cycle; refetch from target next cycle; no further bubbles from this block.
//  - Load-use with branch same cycle: branch wins (stalled instr is flushed anyway).
//  - ack while mem_access=0: ignored.
//  - Reset mid-MEM_WAIT: immediate return to RUN; memory must tolerate dropped req.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: in MEM_WAIT, wait count==TIMEOUT_CYC & !dmem_ack -> ERR next edge.
//    ERR: err=1, all *_en 0, flushes 0, dmem_req 0, stall_cnt frozen. Only rst_n exits ERR.
//    Ack in the timeout cycle wins (-> RUN).
//  MEM_TIMEOUT_EN undefined: no ERR state, err tied 0, MEM_WAIT unbounded.
// TESTING
//  1 Reset: rst_n=0 mid-run -> flushes 1, *_en 0, stall_cnt 0, err 0, async (no clk edge needed).
//  2 Load-use: ex_memread=1, ex_rt=8, id_rs=8 -> 1 cycle pc_en=ifid_en=0, idex_flush=1; stall_cnt +1.
//    ex_rt=0 -> no stall.
//  3 Branch: mem_branch=1, mem_zero=1 with load-use also true -> pc_src=1, 3 flushes=1, all *_en 1,
//    stall_cnt unchanged.
//  4 Mem wait: mem_access=1, ack after 4 cycles -> 4 freeze cycles (dmem_req=1, *_en 0),
//    then advance; stall_cnt +4. Ack same cycle -> 0 freezes.
//  5 Saturation: CNT_W=4, 20 stall cycles -> stall_cnt holds 15.
//  6 MEM_TIMEOUT_EN, TIMEOUT_CYC=5, no ack -> err=1 after 6th MEM_WAIT cycle, dmem_req 0,
//    sticky until rst_n. Ack on that cycle -> RUN, err 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencer for the 5-stage MIPS core. It handles load-use
//               stalls, flushes for branches resolved in MEM, data-memory freeze,
//               and keeps a saturating stall counter.
//               Optional memory timeout / ERR state: define MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int WAIT_W      = 8,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_ex_memread,
    input  logic [4:0]       i_ex_rt,
    input  logic             i_mem_branch,
    input  logic             i_mem_zero,
    input  logic             i_mem_access,
    input  logic             i_dmem_ack,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_idex_en,
    output logic             o_exmem_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_exmem_flush,
    output logic             o_pc_src,
    output logic             o_dmem_req,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic             o_err
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_active;
    logic w_freeze;
    logic w_branch;
    logic w_lu_hit;
    logic w_loaduse;
    logic w_stall_cycle;

    // A parameter set whose timeout cannot be reached by the wait counter is rejected at elaboration.
    generate
        if (TIMEOUT_CYC >= (1 << WAIT_W)) begin : g_bad_timeout
            $error("hazard_ctrl: TIMEOUT_CYC must be below 2**WAIT_W");
        end
    endgenerate

    assign w_active      = (r_state != S_ERR);
    assign w_freeze      = w_active & i_mem_access & ~i_dmem_ack;
    assign w_branch      = w_active & i_mem_branch & i_mem_zero;
    assign w_lu_hit      = i_ex_memread & (i_ex_rt != 5'd0) &
                           ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));
    assign w_loaduse     = w_active & w_lu_hit & ~w_freeze & ~w_branch;
    assign w_stall_cycle = w_freeze | w_loaduse;

    // Output decode: priority freeze > branch > load-use > normal.
    always_comb begin
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_idex_en     = 1'b0;
        o_exmem_en    = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_exmem_flush = 1'b0;
        o_pc_src      = 1'b0;
        o_dmem_req    = 1'b0;
        if (!rst_n) begin
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_flush = 1'b1;
        end else if (w_active) begin
            o_dmem_req = i_mem_access;
            if (w_freeze) begin
                o_pc_en = 1'b0;
            end else if (w_branch) begin
                o_pc_en       = 1'b1;
                o_ifid_en     = 1'b1;
                o_idex_en     = 1'b1;
                o_exmem_en    = 1'b1;
                o_ifid_flush  = 1'b1;
                o_idex_flush  = 1'b1;
                o_exmem_flush = 1'b1;
                o_pc_src      = 1'b1;
            end else if (w_loaduse) begin
                o_idex_en    = 1'b1;
                o_exmem_en   = 1'b1;
                o_idex_flush = 1'b1;
            end else begin
                o_pc_en    = 1'b1;
                o_ifid_en  = 1'b1;
                o_idex_en  = 1'b1;
                o_exmem_en = 1'b1;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err;
    logic              w_timeout;

    assign w_timeout = (r_wait_cnt == TIMEOUT_CYC[WAIT_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_RUN) && (w_state_nxt == S_MEM_WAIT)) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_MEM_WAIT) && (r_wait_cnt != {WAIT_W{1'b1}})) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_state_nxt == S_ERR) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    logic w_timeout;

    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    // MEM_WAIT is left as soon as the freeze condition clears; an ack in the timeout cycle wins.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_freeze) begin
                    w_state_nxt = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (!w_freeze) begin
                    w_state_nxt = S_RUN;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ERR: begin
`ifdef MEM_TIMEOUT_EN
                w_state_nxt = S_ERR;
`else
                w_state_nxt = S_RUN;
`endif
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_cycle && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
